fabosc_tick_gen: RTL

- Parametrised successor to the fabric oscillator wrapper.
- Runs on the RCOSC 25/50 MHz fabric clock (the CLKINT-buffered O2F net).
- Generates N_CH independently programmable, glitch-free clock-enable ticks for fabric logic.
- Also monitors a second oscillator (XTLOSC O2F) by edge counting over a fixed window, so the system block can detect a dead or off-frequency crystal.

---
 rtl/fabosc_pkg.sv | 17 +
 rtl/fabosc_tick_ch.sv | 46 ++++
 rtl/fabosc_tick_gen.sv | 119 +++++++++++
 3 files changed

// File: rtl/fabosc_pkg.sv
// rtl/fabosc_pkg.sv - shared defaults, types and width helper for the fabric tick generator
package fabosc_pkg;

    localparam int DIV_W_DEF       = 16;
    localparam int DEFAULT_DIV     = 50;
    localparam int DEFAULT_WIN_CYC = 50000;
    localparam int DEFAULT_MON_MIN = 3200;
    localparam int DEFAULT_MON_MAX = 3300;

    typedef logic [DIV_W_DEF-1:0] div_t;

    // Index width that never collapses to zero bits for a single-entry range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fabosc_tick_ch.sv
// rtl/fabosc_tick_ch.sv - one programmable clock-enable tick channel with glitch-free divisor update
module fabosc_tick_ch
    import fabosc_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int DEF_DIV = DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             restart,
    input  logic             pend_hit,
    input  logic [DIV_W-1:0] pend_div,
    output logic             apply,
    output logic             tick
);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] cnt;
    logic             last;

    // Divisors 0 and 1 both mean "every cycle".
    assign last = (div <= DIV_W'(1)) || (cnt == div - DIV_W'(1));

    // New divisor only lands where the counter restarts, so no period is cut short or stretched.
    assign apply = pend_hit & (~en | last | restart);

    always_ff @(posedge clk) begin
        if (reset) begin
            div  <= DIV_W'(DEF_DIV);
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            if (apply) begin
                div <= pend_div;
            end
            if (!en || restart || last) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            tick <= en & last & ~restart;
        end
    end

endmodule

// File: rtl/fabosc_tick_gen.sv
// rtl/fabosc_tick_gen.sv - N-channel fabric tick generator with crystal oscillator frequency monitor
module fabosc_tick_gen
    import fabosc_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int DIV_W   = 16,
    parameter int DEF_DIV = DEFAULT_DIV,
    parameter int WIN_CYC = DEFAULT_WIN_CYC,
    parameter int CNT_W   = 16,
    parameter int MON_MIN = DEFAULT_MON_MIN,
    parameter int MON_MAX = DEFAULT_MON_MAX
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     CFG_VALID,
    output logic                     CFG_READY,
    input  logic [idx_w(N_CH)-1:0]   CFG_CH,
    input  logic [DIV_W-1:0]         CFG_DIV,
    input  logic [N_CH-1:0]          CH_EN,
    input  logic                     SYNC_RESTART,
    output logic [N_CH-1:0]          TICK,
    input  logic                     MON_IN,
    output logic [CNT_W-1:0]         MON_COUNT,
    output logic                     MON_VALID,
    output logic                     MON_FAIL
);

    localparam int CH_W  = idx_w(N_CH);
    localparam int WIN_W = idx_w(WIN_CYC);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MON_MIN);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MON_MAX);

    logic                 pend_valid;
    logic [CH_W-1:0]      pend_ch;
    logic [DIV_W-1:0]     pend_div;
    logic [N_CH-1:0]      applied;
    logic [2**CH_W-1:0]   ch_ok;
    logic                 xfer;

    assign CFG_READY = ~pend_valid;
    assign xfer      = CFG_VALID & CFG_READY;

    for (genvar j = 0; j < 2**CH_W; j++) begin : g_ok
        assign ch_ok[j] = (j < N_CH);
    end

    // Out-of-range channel numbers complete the handshake but never occupy the slot.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pend_valid <= 1'b0;
            pend_ch    <= '0;
            pend_div   <= '0;
        end else if (|applied) begin
            pend_valid <= 1'b0;
        end else if (xfer && ch_ok[CFG_CH]) begin
            pend_valid <= 1'b1;
            pend_ch    <= CFG_CH;
            pend_div   <= CFG_DIV;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        fabosc_tick_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk      (CLK),
            .reset    (RESET),
            .en       (CH_EN[i]),
            .restart  (SYNC_RESTART),
            .pend_hit (pend_valid && (pend_ch == CH_W'(i))),
            .pend_div (pend_div),
            .apply    (applied[i]),
            .tick     (TICK[i])
        );
    end

    logic             mon_s1;
    logic             mon_s2;
    logic             mon_prev;
    logic             mon_rise;
    logic [WIN_W-1:0] win;
    logic [CNT_W-1:0] edges;
    logic [CNT_W-1:0] edges_next;

    assign mon_rise   = mon_s2 & ~mon_prev;
    assign edges_next = (mon_rise && (edges != '1)) ? edges + 1'b1 : edges;

    // The window-end result includes an edge seen in the final cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mon_s1    <= 1'b0;
            mon_s2    <= 1'b0;
            mon_prev  <= 1'b0;
            win       <= '0;
            edges     <= '0;
            MON_COUNT <= '0;
            MON_VALID <= 1'b0;
            MON_FAIL  <= 1'b0;
        end else begin
            mon_s1    <= MON_IN;
            mon_s2    <= mon_s1;
            mon_prev  <= mon_s2;
            MON_VALID <= 1'b0;
            if (win == WIN_LAST) begin
                win       <= '0;
                edges     <= '0;
                MON_COUNT <= edges_next;
                MON_VALID <= 1'b1;
                MON_FAIL  <= (edges_next < MIN_C) | (edges_next > MAX_C);
            end else begin
                win   <= win + 1'b1;
                edges <= edges_next;
            end
        end
    end

endmodule
